button_event_arbiter: RTL and testbench

Turns the debounced button levels from the per-button `Debouncer` instances into a single stream of discrete events: press, release and long-press. Events go out on a valid/ready port. The block sits between the debouncers and the game/UI control FSM. It tracks every button independently and shares the one event port among buttons with a round-robin arbiter. Buttons that fire together therefore cannot starve each other.

---
 rtl/button_evt_pkg.sv | 17 +
 rtl/button_event_tracker.sv | 61 ++++++
 rtl/button_event_arbiter.sv | 92 +++++++++
 tb/tb_button_event_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/button_evt_pkg.sv
// rtl/button_evt_pkg.sv - event type encoding and pending-flag merge helper for the button event arbiter
package button_evt_pkg;

    typedef logic [1:0] evt_type_t;

    localparam evt_type_t EVT_NONE    = 2'b00;
    localparam evt_type_t EVT_PRESS   = 2'b01;
    localparam evt_type_t EVT_RELEASE = 2'b10;
    localparam evt_type_t EVT_LONG    = 2'b11;

    // Arbitration sees flag|set, so a clear consumes the stored flag if present,
    // otherwise the same-cycle set; a new set on top of a consumed flag survives.
    function automatic logic merge_flag(input logic flag, input logic set, input logic clr);
        return clr ? (flag & set) : (flag | set);
    endfunction

endpackage

// File: rtl/button_event_tracker.sv
// rtl/button_event_tracker.sv - per-button edge detect, hold counter and press/release/long pending flags
module button_event_tracker
    import button_evt_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic clr_p,
    input  logic clr_r,
    input  logic clr_l,
    output logic pend_p,
    output logic pend_r,
    output logic pend_l,
    output logic overrun
);

    localparam int CNT_W = (LONG_PRESS_CYCLES > 2) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ARM  = CNT_W'(LONG_PRESS_CYCLES - 2);

    logic             prev;
    logic             flag_p, flag_r, flag_l;
    logic [CNT_W-1:0] cnt;
    logic             rise, fall, set_l;

    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
    // Fires on the step into CNT_LAST; saturation then keeps it to one LONG per press.
    assign set_l = level & ~rise & (cnt == CNT_ARM);

    assign pend_p = flag_p | rise;
    assign pend_r = flag_r | fall;
    assign pend_l = flag_l | set_l;

    assign overrun = (rise  & flag_p & ~clr_p)
                   | (fall  & flag_r & ~clr_r)
                   | (set_l & flag_l & ~clr_l);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev   <= 1'b0;
            flag_p <= 1'b0;
            flag_r <= 1'b0;
            flag_l <= 1'b0;
            cnt    <= '0;
        end else begin
            prev   <= level;
            flag_p <= merge_flag(flag_p, rise, clr_p);
            flag_r <= merge_flag(flag_r, fall, clr_r);
            flag_l <= merge_flag(flag_l, set_l, clr_l);
            if (rise || fall) begin
                cnt <= '0;
            end else if (level && cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - round-robin merge of per-button press/release/long events onto one valid/ready port
module button_event_arbiter
    import button_evt_pkg::*;
#(
    parameter int NUM_BTN           = 4,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int IDX_W             = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_level,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDX_W-1:0]   evt_btn,
    output logic [1:0]         evt_type,
    output logic               overrun
);

    logic [NUM_BTN-1:0] pend_p, pend_r, pend_l, eligible;
    logic [NUM_BTN-1:0] clr_p, clr_r, clr_l, ovr;
    logic [IDX_W-1:0]   rr, win, rr_next;
    logic               found, load;
    evt_type_t          sel_type;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        button_event_tracker #(
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_tracker (
            .clk    (clk),
            .reset  (reset),
            .level  (btn_level[g]),
            .clr_p  (clr_p[g]),
            .clr_r  (clr_r[g]),
            .clr_l  (clr_l[g]),
            .pend_p (pend_p[g]),
            .pend_r (pend_r[g]),
            .pend_l (pend_l[g]),
            .overrun(ovr[g])
        );
    end

    assign eligible = pend_p | pend_r | pend_l;
    assign load     = !evt_valid || evt_ready;

    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        win      = '0;
        sel_type = EVT_RELEASE;
        clr_p    = '0;
        clr_r    = '0;
        clr_l    = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            idx = int'(rr) + k;
            if (idx >= NUM_BTN) idx = idx - NUM_BTN;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
        if (pend_p[win])      sel_type = EVT_PRESS;
        else if (pend_l[win]) sel_type = EVT_LONG;
        if (load && found) begin
            clr_p[win] = (sel_type == EVT_PRESS);
            clr_l[win] = (sel_type == EVT_LONG);
            clr_r[win] = (sel_type == EVT_RELEASE);
        end
        rr_next = (win == IDX_W'(NUM_BTN - 1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_valid <= 1'b0;
            evt_btn   <= '0;
            evt_type  <= EVT_NONE;
            overrun   <= 1'b0;
            rr        <= '0;
        end else begin
            overrun <= |ovr;
            if (load) begin
                evt_valid <= found;
                if (found) begin
                    evt_btn  <= win;
                    evt_type <= sel_type;
                    rr       <= rr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - directed scoreboard bench for button_event_arbiter
module tb_button_event_arbiter;
    import button_evt_pkg::*;

    localparam int NB  = 4;
    localparam int LPC = 20;
    localparam int IW  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] btn_level = '0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [IW-1:0] evt_btn;
    logic [1:0]    evt_type;
    logic          overrun;

    int total = 0, bad = 0, cyc = 0, ovr_cnt = 0, acc_cnt = 0;
    int press_cyc[NB];
    int long_cyc = -1;
    int d, o0, a0;
    logic [3:0] sb[$];
    logic [3:0] exp_e;

    button_event_arbiter #(
        .NUM_BTN(NB),
        .LONG_PRESS_CYCLES(LPC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_level(btn_level),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_btn  (evt_btn),
        .evt_type (evt_type),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && overrun) ovr_cnt++;
        if (reset && evt_valid && evt_ready) begin
            acc_cnt++;
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL evt_unexpected got btn=%0d type=%0d want none", evt_btn, evt_type);
            end
            if (sb.size() != 0) begin
                exp_e = sb.pop_front();
                total++;
                assert ({evt_btn, evt_type} === exp_e) else begin
                    bad++;
                    $error("FAIL evt_order got btn=%0d type=%0d want btn=%0d type=%0d",
                           evt_btn, evt_type, exp_e[3:2], exp_e[1:0]);
                end
            end
            if (evt_type == EVT_PRESS) press_cyc[evt_btn] = cyc;
            if (evt_type == EVT_LONG)  long_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int b, input evt_type_t t);
        sb.push_back({b[1:0], t});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        chk(tag, sb.size(), 0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        btn_level = '0;
        sb.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_btn", evt_btn, 0);
        chk("rst_type", evt_type, 0);
        chk("rst_overrun", overrun, 0);
        tick();
        reset = 1'b1;
        tick();

        // single press/release on btn 2
        evt_ready = 1'b1;
        o0 = ovr_cnt;
        btn_level[2] = 1'b1;
        d = cyc;
        push(2, EVT_PRESS);
        repeat (5) tick();
        btn_level[2] = 1'b0;
        push(2, EVT_RELEASE);
        drain("s1_drain");
        chk("s1_press_lat", press_cyc[2], d + 1);
        chk("s1_no_overrun", ovr_cnt - o0, 0);

        // long hold on btn 1
        btn_level[1] = 1'b1;
        d = cyc;
        push(1, EVT_PRESS);
        push(1, EVT_LONG);
        repeat (40) tick();
        btn_level[1] = 1'b0;
        push(1, EVT_RELEASE);
        drain("s2_drain");
        chk("s2_press_lat", press_cyc[1], d + 1);
        chk("s2_long_lat", long_cyc, d + LPC);

        // simultaneous rise, rr starts at 0
        do_reset();
        evt_ready = 1'b1;
        btn_level = 4'hF;
        d = cyc;
        for (int b = 0; b < NB; b++) push(b, EVT_PRESS);
        drain("s3_drain_press");
        chk("s3_first", press_cyc[0], d + 1);
        chk("s3_last", press_cyc[3], d + 4);
        chk("s3_rr", dut.rr, 0);
        btn_level = 4'h0;
        for (int b = 0; b < NB; b++) push(b, EVT_RELEASE);
        drain("s3_drain_rel");

        // backpressure on btn 3
        evt_ready = 1'b0;
        btn_level[3] = 1'b1;
        push(3, EVT_PRESS);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("s4_hold", {evt_valid, evt_btn, evt_type}, {1'b1, 2'd3, EVT_PRESS});
            if (i == 3) begin
                btn_level[3] = 1'b0;
                push(3, EVT_RELEASE);
            end
            tick();
        end
        evt_ready = 1'b1;
        drain("s4_drain");

        // overrun: btn 0 rises twice while its press is still pending
        evt_ready = 1'b0;
        o0 = ovr_cnt;
        btn_level[3] = 1'b1;
        push(3, EVT_PRESS);
        tick();
        btn_level[0] = 1'b1;
        push(0, EVT_PRESS);
        tick();
        btn_level[0] = 1'b0;
        push(0, EVT_RELEASE);
        tick();
        btn_level[0] = 1'b1;
        repeat (2) tick();
        chk("s5_overrun_pulse", ovr_cnt - o0, 1);
        evt_ready = 1'b1;
        repeat (6) tick();
        btn_level[0] = 1'b0;
        push(0, EVT_RELEASE);
        repeat (3) tick();
        btn_level[3] = 1'b0;
        push(3, EVT_RELEASE);
        drain("s5_drain");
        chk("s5_overrun_total", ovr_cnt - o0, 1);

        // async reset with events pending
        evt_ready = 1'b0;
        btn_level = 4'b0111;
        repeat (2) tick();
        chk("s6_valid_pre", evt_valid, 1);
        #1 reset = 1'b0;
        #1;
        chk("s6_valid_async", evt_valid, 0);
        chk("s6_btn_async", evt_btn, 0);
        chk("s6_type_async", evt_type, 0);
        chk("s6_ovr_async", overrun, 0);
        btn_level = '0;
        sb.delete();
        repeat (2) tick();
        reset = 1'b1;
        evt_ready = 1'b1;
        a0 = acc_cnt;
        repeat (10) tick();
        chk("s6_no_stale", acc_cnt - a0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
